snake_ctrl: RTL and testbench
=============================

SNAKE_CTRL -- requirements
Module: snake_ctrl

Interface
REQ-001 Parameter GRID_W, default 40, grid width in cells.
REQ-002 Parameter GRID_H, default 30, grid height in cells.
REQ-003 Parameter FRAMES_PER_STEP, default 8, frame ticks per snake move (range 1..255).
REQ-004 clk  input  1  system clock, single domain; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 key  input  4  raw button levels: [0] up, [1] down, [2] left, [3] right; asynchronous to clk.
REQ-007 frame_tick  input  1  one-cycle pulse per video frame.
REQ-008 self_hit  input  1  head-on-body flag from the body store, sampled in RUN only.
REQ-009 head_x  output  6  head column, 0..GRID_W-1.
REQ-010 head_y  output  6  head row, 0..GRID_H-1.
REQ-011 dir  output  2  current direction: 00 up, 01 down, 10 left, 11 right.
REQ-012 move_stb  output  1  one-cycle pulse when the head has just moved.
REQ-013 state  output  2  00 IDLE, 01 RUN, 10 OVER.
REQ-014 game_over  output  1  high while state is OVER.

Function
REQ-015 key shall pass through a 2-flop synchronizer; all logic uses only synchronized key (key_s).
REQ-016 FSM shall have exactly three states: IDLE, RUN, OVER; code 11 unreachable, recovers to IDLE next cycle.
REQ-017 IDLE->RUN on the first cycle key_s is nonzero; that key sets dir_next by the REQ-020 rules, except reversal of the reset direction is also accepted.
REQ-018 RUN->OVER on self_hit=1 or on a wall-collision step (REQ-024); OVER is terminal until rst.
REQ-019 In IDLE and OVER: step counter held at 0, head_x/head_y/dir frozen, move_stb=0.
REQ-020 In RUN, each cycle key_s is nonzero, dir_next shall load the highest-priority pressed key (up>down>left>right) unless it is the reverse of dir (current, not dir_next); reversals are ignored, dir_next unchanged.
REQ-021 In RUN, step counter (8 bit) increments on frame_tick; frame_tick arriving with counter = FRAMES_PER_STEP-1 is a step event and clears counter to 0.
REQ-022 On the clock edge completing a step event: dir<=dir_next; head moves one cell in dir_next (up: y-1, down: y+1, left: x-1, right: x+1); move_stb=1 for exactly that following cycle.
REQ-023 Latency: head_x/head_y/dir/move_stb valid on the cycle immediately after the frame_tick cycle that completes the step.
REQ-024 Wall collision: step moving beyond x=0, x=GRID_W-1, y=0 or y=GRID_H-1 shall not move the head or pulse move_stb; dir still updates; state<=OVER; no wrap-around.
REQ-025 self_hit and step event in the same cycle: OVER wins; no move, no move_stb.
REQ-026 Key change and step event in the same cycle: the step uses dir_next before that key; the key applies to the next step.
REQ-027 Two non-reversing keys between steps: last accepted wins.
REQ-028 frame_tick in the cycle of IDLE->RUN shall not be counted.

Reset
REQ-029 rst=1 shall asynchronously force: state IDLE, head_x=GRID_W/2 (20), head_y=GRID_H/2 (15), dir=dir_next=11 (right), counter 0, move_stb 0, game_over 0, synchronizer flops 0.
REQ-030 rst asserted mid-RUN or mid-step shall discard the pending step; first possible move_stb is FRAMES_PER_STEP frame ticks after re-entering RUN.
REQ-031 Release of rst is assumed synchronous to clk at system level; block itself requires no release synchronizer.

Verification
REQ-032 Reset, key=0100, 8 frame_ticks -> RUN after 3 clk, one move_stb, head=(19,15), dir=10.
REQ-033 RUN heading right, key=1000 then key=0100 (reversal) -> dir stays 11, next step head_x+1.
REQ-034 Run right from (20,15) for 19 steps -> head=(39,15); 20th step -> no move_stb, head (39,15), state OVER, game_over=1; further ticks/keys no effect.
REQ-035 self_hit pulsed in the same cycle as step-completing frame_tick -> OVER, head unchanged, move_stb stays 0.
REQ-036 key=0011 (up+down) from dir right -> dir_next up; next step head_y-1.
REQ-037 rst pulsed between frame ticks mid-RUN (async, not clock-aligned) -> outputs immediately at REQ-029 values; IDLE until next key.

Source files
------------

// File: rtl/snake_ctrl.sv
// Snake game head controller: key synchronizer, IDLE/RUN/OVER FSM, frame-tick step
// counter, direction filtering and head movement with wall collision detection.
module snake_ctrl #(
  parameter int GRID_W          = 40,
  parameter int GRID_H          = 30,
  parameter int FRAMES_PER_STEP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  input  logic       frame_tick,
  input  logic       self_hit,
  output logic [5:0] head_x,
  output logic [5:0] head_y,
  output logic [1:0] dir,
  output logic       move_stb,
  output logic [1:0] state,
  output logic       game_over
);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_OVER = 2'b10} state_e;
  typedef enum logic [1:0] {D_UP = 2'b00, D_DOWN = 2'b01, D_LEFT = 2'b10, D_RIGHT = 2'b11} dir_e;

  localparam logic [5:0] X_START  = 6'(GRID_W / 2);
  localparam logic [5:0] Y_START  = 6'(GRID_H / 2);
  localparam logic [5:0] X_MAX    = 6'(GRID_W - 1);
  localparam logic [5:0] Y_MAX    = 6'(GRID_H - 1);
  localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_STEP - 1);

  function automatic dir_e key_prio(input logic [3:0] k);
    if (k[0])      return D_UP;
    else if (k[1]) return D_DOWN;
    else if (k[2]) return D_LEFT;
    else           return D_RIGHT;
  endfunction

  function automatic dir_e reverse_of(input dir_e d);
    case (d)
      D_UP:    return D_DOWN;
      D_DOWN:  return D_UP;
      D_LEFT:  return D_RIGHT;
      default: return D_LEFT;
    endcase
  endfunction

  logic [3:0] key_meta_q, key_s_q;
  state_e     state_q, state_d;
  dir_e       dir_q, dir_d, dir_next_q, dir_next_d, key_dir;
  logic [5:0] head_x_q, head_x_d, head_y_q, head_y_d, tgt_x, tgt_y;
  logic [7:0] cnt_q, cnt_d;
  logic       move_stb_q, move_stb_d;
  logic       wall;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_meta_q <= '0;
      key_s_q    <= '0;
      state_q    <= S_IDLE;
      dir_q      <= D_RIGHT;
      dir_next_q <= D_RIGHT;
      head_x_q   <= X_START;
      head_y_q   <= Y_START;
      cnt_q      <= '0;
      move_stb_q <= 1'b0;
    end else begin
      key_meta_q <= key;
      key_s_q    <= key_meta_q;
      state_q    <= state_d;
      dir_q      <= dir_d;
      dir_next_q <= dir_next_d;
      head_x_q   <= head_x_d;
      head_y_q   <= head_y_d;
      cnt_q      <= cnt_d;
      move_stb_q <= move_stb_d;
    end
  end

  // Target cell of the pending step, and whether that step would leave the grid.
  always_comb begin
    tgt_x = head_x_q;
    tgt_y = head_y_q;
    wall  = 1'b0;
    case (dir_next_q)
      D_UP:    if (head_y_q == '0)    wall = 1'b1; else tgt_y = head_y_q - 6'd1;
      D_DOWN:  if (head_y_q == Y_MAX) wall = 1'b1; else tgt_y = head_y_q + 6'd1;
      D_LEFT:  if (head_x_q == '0)    wall = 1'b1; else tgt_x = head_x_q - 6'd1;
      default: if (head_x_q == X_MAX) wall = 1'b1; else tgt_x = head_x_q + 6'd1;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    dir_next_d = dir_next_q;
    head_x_d   = head_x_q;
    head_y_d   = head_y_q;
    cnt_d      = cnt_q;
    move_stb_d = 1'b0;
    key_dir    = key_prio(key_s_q);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // Any first key starts the game, even one reversing the reset heading.
        if (|key_s_q) begin
          state_d    = S_RUN;
          dir_next_d = key_dir;
        end
      end
      S_RUN: begin
        if (|key_s_q && key_dir != reverse_of(dir_q)) dir_next_d = key_dir;
        if (frame_tick) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 8'd1;
        if (self_hit) begin
          state_d = S_OVER;
          cnt_d   = '0;
        end else if (frame_tick && cnt_q == CNT_LAST) begin
          dir_d = dir_next_q;
          if (wall) begin
            state_d = S_OVER;
          end else begin
            head_x_d   = tgt_x;
            head_y_d   = tgt_y;
            move_stb_d = 1'b1;
          end
        end
      end
      S_OVER: cnt_d = '0;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign head_x    = head_x_q;
  assign head_y    = head_y_q;
  assign dir       = dir_q;
  assign move_stb  = move_stb_q;
  assign state     = state_q;
  assign game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_snake_ctrl.sv
// Bench for snake_ctrl: a grid-level game model checked against the DUT every
// negative clock edge, plus directed scenarios with hand-computed positions.
module tb_snake_ctrl;
  localparam int FPS = 8;
  localparam int GW  = 40;
  localparam int GH  = 30;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic       frame_tick, self_hit;
  logic [5:0] head_x, head_y;
  logic [1:0] dir, state;
  logic       move_stb, game_over;

  always #5 clk = ~clk;

  snake_ctrl #(.GRID_W(GW), .GRID_H(GH), .FRAMES_PER_STEP(FPS)) dut (
    .clk(clk), .rst(rst), .key(key), .frame_tick(frame_tick), .self_hit(self_hit),
    .head_x(head_x), .head_y(head_y), .dir(dir), .move_stb(move_stb),
    .state(state), .game_over(game_over)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int stb_seen = 0;
  bit chk_en = 1'b0;

  // Game model: state 0 idle, 1 run, 2 over; direction code equals the key bit index.
  int m_state, m_x, m_y, m_dir, m_dnext, m_cnt, m_stb, m_k1, m_ks;
  int dx[4] = '{0, 0, -1, 1};
  int dy[4] = '{-1, 1, 0, 0};

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int prio(input int k);
    for (int i = 0; i < 4; i++) if (k[i]) return i;
    return 3;
  endfunction

  task automatic model_reset();
    m_state = 0; m_x = GW / 2; m_y = GH / 2; m_dir = 3; m_dnext = 3;
    m_cnt = 0; m_stb = 0; m_k1 = 0; m_ks = 0;
  endtask

  task automatic model_clock(input int k, input int ft, input int sh);
    int od, odn, nx, ny;
    od = m_dir; odn = m_dnext; m_stb = 0;
    if (m_state == 0) begin
      if (m_ks != 0) begin
        m_state = 1;
        m_dnext = prio(m_ks);
        m_cnt   = 0;
      end
    end else if (m_state == 1) begin
      if (m_ks != 0 && prio(m_ks) != (od ^ 1)) m_dnext = prio(m_ks);
      if (sh != 0) begin
        m_state = 2;
        m_cnt   = 0;
      end else if (ft != 0) begin
        m_cnt++;
        if (m_cnt == FPS) begin
          m_cnt = 0;
          m_dir = odn;
          nx = m_x + dx[odn];
          ny = m_y + dy[odn];
          if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) m_state = 2;
          else begin
            m_x = nx; m_y = ny; m_stb = 1;
          end
        end
      end
    end
    m_ks = m_k1;
    m_k1 = k;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("state", int'(state), m_state);
      check("head_x", int'(head_x), m_x);
      check("head_y", int'(head_y), m_y);
      check("dir", int'(dir), m_dir);
      check("move_stb", int'(move_stb), m_stb);
      check("game_over", int'(game_over), (m_state == 2) ? 1 : 0);
    end
  end

  task automatic cycle(input int k, input int ft, input int sh);
    key = 4'(k); frame_tick = 1'(ft); self_hit = 1'(sh);
    @(posedge clk);
    if (rst) model_reset(); else model_clock(k, ft, sh);
    #1;
    if (move_stb) stb_seen++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(0, 1, 0);
      cycle(0, 0, 0);
    end
  endtask

  task automatic hw_reset();
    rst = 1'b1;
    model_reset();
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    rst = 1'b0;
    stb_seen = 0;
  endtask

  task automatic start(input int k);
    cycle(k, 0, 0); cycle(k, 0, 0); cycle(k, 0, 0);
    cycle(0, 0, 0); cycle(0, 0, 0);
  endtask

  task automatic expect_pos(input string tag, input int x, input int y, input int d);
    check({tag, "_x"}, int'(head_x), x);
    check({tag, "_y"}, int'(head_y), y);
    check({tag, "_dir"}, int'(dir), d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; key = '0; frame_tick = 1'b0; self_hit = 1'b0;
    model_reset();
    #1 chk_en = 1'b1;
    cycle(0, 0, 0); cycle(0, 0, 0);
    rst = 1'b0;
    check("rst_state", int'(state), 0);
    expect_pos("rst", 20, 15, 3);
    check("rst_stb", int'(move_stb), 0);
    check("rst_over", int'(game_over), 0);

    // Left key from reset: RUN after three clocks, tick on the transition is ignored.
    cycle(4, 0, 0); cycle(4, 0, 0);
    check("idle_before_sync", int'(state), 0);
    cycle(4, 1, 0);
    check("run_after_3clk", int'(state), 1);
    cycle(0, 0, 0); cycle(0, 0, 0);
    stb_seen = 0;
    ticks(7);
    check("no_move_7_ticks", stb_seen, 0);
    expect_pos("seven", 20, 15, 3);
    cycle(0, 1, 0);
    check("stb_after_step", int'(move_stb), 1);
    expect_pos("left_step", 19, 15, 2);
    cycle(0, 0, 0);
    check("stb_one_cycle", int'(move_stb), 0);
    check("one_stb", stb_seen, 1);

    // Heading right, reversal to left ignored.
    hw_reset();
    start(8);
    cycle(8, 0, 0); cycle(8, 0, 0); cycle(4, 0, 0); cycle(4, 0, 0);
    cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    ticks(8);
    expect_pos("reversal", 21, 15, 3);

    // Up+down together picks up.
    cycle(3, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    ticks(8);
    expect_pos("updown", 21, 14, 0);

    // Key reaching key_s in the step cycle applies to the following step.
    ticks(7);
    cycle(8, 0, 0); cycle(0, 0, 0); cycle(0, 1, 0);
    expect_pos("key_same_cycle", 21, 13, 0);
    cycle(0, 0, 0);
    ticks(8);
    expect_pos("key_next_step", 22, 13, 3);

    // Two accepted keys between steps: the last one wins.
    cycle(1, 0, 0); cycle(2, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    ticks(8);
    expect_pos("last_key_wins", 22, 14, 1);

    // self_hit together with the step-completing tick.
    stb_seen = 0;
    ticks(7);
    cycle(0, 1, 1);
    check("selfhit_state", int'(state), 2);
    check("selfhit_stb", int'(move_stb), 0);
    check("selfhit_x", int'(head_x), 22);
    check("selfhit_y", int'(head_y), 14);
    ticks(10);
    start(4);
    ticks(9);
    check("over_terminal", int'(state), 2);
    check("over_no_stb", stb_seen, 0);
    check("over_frozen_y", int'(head_y), 14);

    // Run right into the east wall.
    hw_reset();
    start(8);
    ticks(19 * FPS);
    check("wall_19_moves", stb_seen, 19);
    expect_pos("wall_edge", 39, 15, 3);
    ticks(FPS);
    check("wall_no_stb", stb_seen, 19);
    check("wall_state", int'(state), 2);
    check("wall_over", int'(game_over), 1);
    expect_pos("wall_hold", 39, 15, 3);
    start(1);
    ticks(2 * FPS);
    check("wall_after_x", int'(head_x), 39);
    check("wall_after_stb", stb_seen, 19);

    // Asynchronous reset mid-step, then restart with a fresh step count.
    hw_reset();
    start(4);
    ticks(4);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_state", int'(state), 0);
    expect_pos("async", 20, 15, 3);
    check("async_over", int'(game_over), 0);
    cycle(0, 0, 0); cycle(0, 0, 0);
    rst = 1'b0;
    cycle(0, 1, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    check("idle_until_key", int'(state), 0);
    start(1);
    stb_seen = 0;
    ticks(7);
    check("restart_no_early_stb", stb_seen, 0);
    check("restart_y_hold", int'(head_y), 15);
    ticks(1);
    check("restart_one_stb", stb_seen, 1);
    expect_pos("restart", 20, 14, 0);

    cycle(0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
